// File: rtl/sha256_msg_sched.sv
// SHA-256 message schedule expander: loads W0..W15, then streams W0..W63 over valid/ready.
// Optional SHA256_SCHED_ABORT_EN adds an abort input that returns the block to LOAD.
module sha256_msg_sched #(
  parameter int WORD_W = 32,
  parameter int ROUNDS = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WORD_W-1:0] in_word,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WORD_W-1:0] out_word,
  output logic [5:0]        out_idx,
  output logic              out_last
`ifdef SHA256_SCHED_ABORT_EN
  ,
  input  logic              abort
`endif
);

  typedef enum logic {S_LOAD, S_EMIT} state_t;

  state_t            r_state;
  state_t            w_state_next;
  logic [3:0]        r_cnt;
  logic [5:0]        r_idx;
  logic              r_in_ready;
  logic              r_out_valid;
  logic [WORD_W-1:0] r_w [16];

  logic              w_abort;
  logic              w_in_fire;
  logic              w_out_fire;
  logic              w_idx_last;
  logic [WORD_W-1:0] w_new;

  function automatic logic [WORD_W-1:0] rotr(input logic [WORD_W-1:0] x, input int n);
    return (x >> n) | (x << (WORD_W - n));
  endfunction

  function automatic logic [WORD_W-1:0] sig0(input logic [WORD_W-1:0] x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [WORD_W-1:0] sig1(input logic [WORD_W-1:0] x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

`ifdef SHA256_SCHED_ABORT_EN
  assign w_abort = abort;
`else
  assign w_abort = 1'b0;
`endif

  // Abort wins over both handshakes, so neither fire may happen alongside it.
  assign w_in_fire  = (r_state == S_LOAD) && r_in_ready && in_valid && !w_abort;
  assign w_out_fire = (r_state == S_EMIT) && r_out_valid && out_ready && !w_abort;
  assign w_idx_last = (r_idx == 6'(ROUNDS - 1));
  assign w_new      = sig1(r_w[14]) + r_w[9] + sig0(r_w[1]) + r_w[0];

  always_comb begin
    w_state_next = r_state;
    if (w_abort) begin
      w_state_next = S_LOAD;
    end else begin
      case (r_state)
        S_LOAD: if (w_in_fire && (r_cnt == 4'd15)) w_state_next = S_EMIT;
        S_EMIT: if (w_out_fire && w_idx_last) w_state_next = S_LOAD;
        default: w_state_next = S_LOAD;
      endcase
    end
  end

  // Handshake flags are registered copies of the next state, so in_ready stays
  // low for the whole reset and rises on the first edge after release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_LOAD;
      r_in_ready  <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_in_ready  <= (w_state_next == S_LOAD);
      r_out_valid <= (w_state_next == S_EMIT);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
      r_idx <= '0;
    end else if (w_abort) begin
      r_cnt <= '0;
      r_idx <= '0;
    end else begin
      if (w_in_fire) r_cnt <= r_cnt + 4'd1;
      if (w_out_fire) r_idx <= w_idx_last ? 6'd0 : r_idx + 6'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 16; i++) r_w[i] <= '0;
    end else if (w_in_fire) begin
      r_w[r_cnt] <= in_word;
    end else if (w_out_fire) begin
      for (int i = 0; i < 15; i++) r_w[i] <= r_w[i+1];
      r_w[15] <= w_new;
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign out_word  = r_out_valid ? r_w[0] : '0;
  assign out_idx   = r_idx;
  assign out_last  = r_out_valid && w_idx_last;

endmodule

// File: tb/tb_sha256_msg_sched.sv
// Self-checking bench for sha256_msg_sched: table vectors, stalls, reset, back-to-back
// blocks and random blocks against an array-based schedule model (abort with SHA256_SCHED_ABORT_EN).
module tb_sha256_msg_sched;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_word = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_word;
  logic [5:0]  out_idx;
  logic        out_last;
`ifdef SHA256_SCHED_ABORT_EN
  logic        abort = 1'b0;
`endif

  sha256_msg_sched #(.WORD_W(32), .ROUNDS(64)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_word   (in_word),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_word  (out_word),
    .out_idx   (out_idx),
    .out_last  (out_last)
`ifdef SHA256_SCHED_ABORT_EN
    ,
    .abort     (abort)
`endif
  );

  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  logic [31:0] cur_blk [16];
  logic [31:0] ref_w   [64];
  logic [31:0] got     [64];

  typedef struct packed {
    logic [511:0] blk;
    logic [31:0]  e16;
    logic [31:0]  e17;
  } vec_t;

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  // Reference schedule from the FIPS 180-4 recurrence over a flat 64-entry array.
  function automatic void build_ref();
    for (int t = 0; t < 16; t++) ref_w[t] = cur_blk[t];
    for (int t = 16; t < 64; t++) begin
      ref_w[t] = (rotr(ref_w[t-2], 17) ^ rotr(ref_w[t-2], 19) ^ (ref_w[t-2] >> 10))
               + ref_w[t-7]
               + (rotr(ref_w[t-15], 7) ^ rotr(ref_w[t-15], 18) ^ (ref_w[t-15] >> 3))
               + ref_w[t-16];
    end
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Called at a negedge; returns at a negedge after n words were accepted.
  task automatic load_block(input int n, input bit gaps, input bit hold_after,
                            input logic [31:0] hold_word);
    int i = 0;
    int cyc = 0;
    bit rdy;
    bit v;
    while (i < n && cyc < 500) begin
      cyc++;
      rdy = in_ready;
      v = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
      in_valid = v;
      in_word  = cur_blk[i];
      @(posedge clk);
      if (rdy && v) i++;
      @(negedge clk);
    end
    if (i < n) chk("load_timeout", 32'(i), 32'(n));
    in_valid = hold_after;
    in_word  = hold_after ? hold_word : 32'h0;
    if (n == 16) chk("w0_latency_valid", 32'(out_valid), 32'd1);
  endtask

  // Called at a negedge in EMIT; consumes the stream and checks it against ref_w.
  task automatic collect(input string tag, input bit rnd, input int stall_t,
                         input int abort_t, input bit hold_in);
    int t = 0;
    int cyc = 0;
    int stall_n = 0;
    bit done = 1'b0;
    bit rdy;
    bit v;
    bit ab;
    while (!done && cyc < 3000) begin
      cyc++;
      v = out_valid;
      chk({tag, "_valid"}, 32'(out_valid), 32'd1);
      chk({tag, "_word"}, out_word, ref_w[t]);
      chk({tag, "_idx"}, 32'(out_idx), 32'(t));
      chk({tag, "_last"}, 32'(out_last), 32'(t == 63));
      if (hold_in) chk({tag, "_in_ready_emit"}, 32'(in_ready), 32'd0);
      if (t == stall_t && stall_n < 5) begin
        rdy = 1'b0;
        stall_n++;
      end else begin
        rdy = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      end
      ab = 1'b0;
`ifdef SHA256_SCHED_ABORT_EN
      if (t == abort_t) begin
        ab = 1'b1;
        rdy = 1'b1;
        abort = 1'b1;
      end
`endif
      out_ready = rdy;
      got[t] = out_word;
      @(posedge clk);
`ifdef SHA256_SCHED_ABORT_EN
      abort = 1'b0;
`endif
      if (ab) begin
        done = 1'b1;
      end else if (rdy && v) begin
        t++;
        if (t == 64) done = 1'b1;
      end
      @(negedge clk);
    end
    out_ready = 1'b0;
    if (!done) chk({tag, "_timeout"}, 32'(t), 32'd64);
    chk({tag, "_valid_after"}, 32'(out_valid), 32'd0);
    chk({tag, "_in_ready_after"}, 32'(in_ready), 32'd1);
    chk({tag, "_idx_after"}, 32'(out_idx), 32'd0);
    chk({tag, "_last_after"}, 32'(out_last), 32'd0);
    $display("%s: %0d words accepted in %0d cycles", tag, t, cyc);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vec_t        vecs [4];
    logic [31:0] hw;

    vecs[0] = '{blk: {32'h61626380, {14{32'h0}}, 32'h00000018}, e16: 32'h61626380, e17: 32'h000F0000};
    vecs[1] = '{blk: {16{32'hFFFFFFFF}}, e16: 32'h203FFFFC, e17: 32'h203FFFFC};
    vecs[2] = '{blk: {16{32'h0}}, e16: 32'h0, e17: 32'h0};
    vecs[3] = '{blk: {32'h00000001, {15{32'h0}}}, e16: 32'h00000001, e17: 32'h0};

    #2 rst_n = 1'b0;
    #2;
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_word", out_word, 32'd0);
    chk("rst_out_idx", 32'(out_idx), 32'd0);
    chk("rst_out_last", 32'(out_last), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rel_in_ready", 32'(in_ready), 32'd1);

    // Table vectors: full stream vs model, W16/W17 vs known constants.
    for (int k = 0; k < 4; k++) begin
      for (int i = 0; i < 16; i++) cur_blk[i] = vecs[k].blk[511 - 32*i -: 32];
      build_ref();
      load_block(16, k[0], 1'b0, 32'h0);
      collect($sformatf("vec%0d", k), 1'b0, -1, -1, 1'b0);
      chk($sformatf("vec%0d_w16", k), got[16], vecs[k].e16);
      chk($sformatf("vec%0d_w17", k), got[17], vecs[k].e17);
    end

    // abc block with random backpressure and a 5-cycle stall at t=20.
    for (int i = 0; i < 16; i++) cur_blk[i] = vecs[0].blk[511 - 32*i -: 32];
    build_ref();
    load_block(16, 1'b0, 1'b0, 32'h0);
    collect("abc_stall", 1'b1, 20, -1, 1'b0);

    // Partial load of 9 words with gaps, then a one-cycle reset.
    for (int i = 0; i < 16; i++) cur_blk[i] = $urandom;
    load_block(9, 1'b1, 1'b0, 32'h0);
    rst_n = 1'b0;
    #1;
    chk("midrst_in_ready", 32'(in_ready), 32'd0);
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_out_word", out_word, 32'd0);
    chk("midrst_out_idx", 32'(out_idx), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 16; i++) cur_blk[i] = $urandom;
    build_ref();
    load_block(16, 1'b0, 1'b0, 32'h0);
    chk("fresh_w0", out_word, cur_blk[0]);
    collect("after_rst", 1'b0, -1, -1, 1'b0);

    // Back-to-back blocks with in_valid held high through EMIT.
    for (int i = 0; i < 16; i++) cur_blk[i] = $urandom;
    build_ref();
    hw = $urandom;
    load_block(16, 1'b0, 1'b1, hw);
    collect("b2b_first", 1'b0, -1, -1, 1'b1);
    cur_blk[0] = hw;
    for (int i = 1; i < 16; i++) cur_blk[i] = $urandom;
    build_ref();
    load_block(16, 1'b0, 1'b0, 32'h0);
    collect("b2b_second", 1'b0, -1, -1, 1'b0);

    // Random blocks, random input gaps and random output backpressure.
    for (int b = 0; b < 3; b++) begin
      for (int i = 0; i < 16; i++) cur_blk[i] = $urandom;
      build_ref();
      load_block(16, 1'b1, 1'b0, 32'h0);
      collect($sformatf("rand%0d", b), 1'b1, -1, -1, 1'b0);
    end

`ifdef SHA256_SCHED_ABORT_EN
    for (int i = 0; i < 16; i++) cur_blk[i] = vecs[0].blk[511 - 32*i -: 32];
    build_ref();
    load_block(16, 1'b0, 1'b0, 32'h0);
    collect("abort_at30", 1'b0, -1, 30, 1'b0);
    for (int i = 0; i < 16; i++) cur_blk[i] = $urandom;
    build_ref();
    load_block(16, 1'b0, 1'b0, 32'h0);
    collect("after_abort", 1'b0, -1, -1, 1'b0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
